// File: rtl/pipeline_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Provides default widths, PC step, reset PC, the bubble instruction and the update-action enum.
package pipeline_defs;

    localparam int          ADDR_W    = 32;
    localparam int          INSTR_W   = 32;
    localparam int          PC_STEP   = 4;
    localparam logic [31:0] PC_RESET  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // What the IF stage does at the next clock edge, highest priority first.
    typedef enum logic [1:0] {
        UPD_REDIRECT,
        UPD_STALL,
        UPD_BUBBLE,
        UPD_ISSUE
    } upd_e;

endpackage

// File: rtl/pipeline_fetch.sv
// IF stage: owns the PC, drives a 1-cycle-latency instruction ROM and registers the IF/ID bundle.
// Ports: clk, rst_n (sync, active low), run, stall, redirect_valid/redirect_pc in;
//        imem_en/imem_addr out, imem_rdata in; id_valid/id_pc/id_pc4/id_instr out.
module pipeline_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc4,
    output logic [INSTR_W-1:0] id_instr
);

    import pipeline_defs::*;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               id_valid_q, id_valid_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
    logic [ADDR_W-1:0]  id_pc4_q, id_pc4_d;
    logic               hold_v_q, hold_v_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    upd_e               upd;

    function automatic logic [ADDR_W-1:0] pc_next(
        input upd_e              u,
        input logic [ADDR_W-1:0] pc,
        input logic [ADDR_W-1:0] tgt
    );
        logic [ADDR_W-1:0] r;
        r = pc;
        unique case (u)
            UPD_REDIRECT: r = tgt & ~ADDR_W'(3);
            UPD_ISSUE:    r = pc + STEP;
            default:      r = pc;
        endcase
        return r;
    endfunction

    // Overlapping conditions resolve in order: redirect > stall > run=0.
    always_comb begin
        upd = UPD_ISSUE;
        priority case (1'b1)
            redirect_valid: upd = UPD_REDIRECT;
            stall:          upd = UPD_STALL;
            !run:           upd = UPD_BUBBLE;
            default:        upd = UPD_ISSUE;
        endcase
    end

    always_comb begin
        pc_d         = pc_next(upd, pc_q, redirect_pc);
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        hold_v_d     = hold_v_q;
        hold_instr_d = hold_instr_q;
        unique case (upd)
            UPD_REDIRECT: begin
                id_valid_d = 1'b0;
                hold_v_d   = 1'b0;
            end
            UPD_STALL: begin
                // ROM data is only valid for one cycle; keep it until release.
                if (!hold_v_q) begin
                    hold_v_d     = 1'b1;
                    hold_instr_d = imem_rdata;
                end
            end
            UPD_BUBBLE: begin
                id_valid_d = 1'b0;
                hold_v_d   = 1'b0;
            end
            UPD_ISSUE: begin
                id_valid_d = 1'b1;
                id_pc_d    = pc_q;
                id_pc4_d   = pc_q + STEP;
                hold_v_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= PC_RESET;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_pc4_q     <= '0;
            hold_v_q     <= 1'b0;
            hold_instr_q <= '0;
        end else begin
            pc_q         <= pc_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            hold_v_q     <= hold_v_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign imem_en   = rst_n && (upd == UPD_ISSUE);
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_pc4    = id_pc4_q;

    // Bubbles present the NOP so stale ROM output never leaks into decode.
    assign id_instr = !id_valid_q ? INSTR_W'(NOP_INSTR)
                    : hold_v_q    ? hold_instr_q
                    :               imem_rdata;

endmodule
